commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-002 Parameter XLEN, default riscv_pkg::XLEN: data/address width of every trace field.
REQ-003 Parameter CH, default 2: number of commit channels; legal range is 1..4.
REQ-004 Parameter DEPTH, default 16: record FIFO entries; must be a power of two, at least 4.
REQ-005 Ports, listed as name, direction, width, meaning:
- clk, in, 1: clock.
- rstn, in, 1: async active-low reset.
- update_i, in, CH: channel commit strobe.
- pc_i, in, CH x XLEN: committed pc.
- instr_i, in, CH x XLEN: instruction word.
- reg_addr_i, in, CH x 5: rd index.
- reg_data_i, in, CH x XLEN: rd write data.
- rf_we_i, in, CH: register file write enable.
- mem_re_i, in, CH: load flag.
- mem_we_i, in, CH: store flag.
- mem_raddr_i, in, CH x XLEN: load address.
- mem_waddr_i, in, CH x XLEN: store address.
- mem_wdata_i, in, CH x XLEN: store data.
- rec_valid_o, out, 1: head record available.
- rec_ready_i, in, 1: consumer accepts the head record.
- rec_o, out, trace_rec_t: head record.
- count_o, out, log2(DEPTH)+1: occupancy.
- drop_cnt_o, out, 32: number of records dropped.
- ovf_o, out, 1: sticky overflow flag.

Function
REQ-006 Each channel with update_i=1 and pc_i!=0 SHALL form a candidate record; a channel with pc_i==0 SHALL be discarded silently and SHALL NOT be counted as a drop.
REQ-007 The record kind SHALL be classified in priority order:
- STORE if mem_we_i; addr=mem_waddr_i, data=mem_wdata_i.
- Otherwise LOAD if mem_re_i and reg_addr_i!=0; rd/data from the register fields, addr=mem_raddr_i.
- Otherwise REG if !mem_re_i, rf_we_i and reg_addr_i!=0.
- Otherwise NONE, carrying pc and instr only; unused fields SHALL be 0.
REQ-008 Candidates from one cycle SHALL be enqueued in ascending channel order, so channel 0 is written first.
REQ-009 Enqueue SHALL be all-or-nothing: if the free slots at the start of the cycle (DEPTH-count_o) are fewer than N candidates, all N SHALL be dropped, drop_cnt_o SHALL increase by N, and ovf_o SHALL be set.
REQ-010 A pop in the same cycle SHALL NOT create space for that cycle's push; the freed slot becomes usable in the next cycle.
REQ-011 A record pushed in cycle t SHALL appear on rec_o with rec_valid_o=1 no earlier than cycle t+1; there is no combinational path from the inputs to rec_o.
REQ-012 The head record SHALL be popped on any edge where rec_valid_o && rec_ready_i; rec_o SHALL remain stable while rec_valid_o=1 and rec_ready_i=0.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH; count_o SHALL equal pushes minus pops and SHALL never exceed DEPTH.
REQ-014 drop_cnt_o SHALL saturate at 0xFFFFFFFF.
REQ-015 ovf_o SHALL clear only on reset.

Reset
REQ-016 While rstn=0, the block SHALL hold rec_valid_o=0, rec_o=0, count_o=0, drop_cnt_o=0, ovf_o=0, and both pointers at 0.
REQ-017 A reset asserted mid-operation SHALL discard all stored records immediately, without waiting for a clock edge.
REQ-018 Inputs sampled on the first edge after rstn deasserts SHALL be processed normally.

Configuration
REQ-019 With TRACE_TSTAMP_EN defined, a free-running 32-bit cycle counter (reset 0, wraps) SHALL be captured into the record field tstamp on push, and all records from one cycle SHALL share the same tstamp.
REQ-020 Without TRACE_TSTAMP_EN, the tstamp field and the counter SHALL be absent, and the record width SHALL shrink accordingly.

Structure
REQ-021 trace_kind_e (NONE, REG, LOAD, STORE) and the packed struct trace_rec_t (kind, pc, instr, rd, data, addr, optional tstamp) SHALL reside in riscv_pkg.
REQ-022 Classification SHALL be a combinational sub-module, trace_classify, instantiated once per channel; the FIFO and counters SHALL be in the top module.

Verification
REQ-023 Single REG commit: ch0 pc=0x80000004, instr=0x00500093, rd=1, data=5, rf_we=1 -> next cycle rec_valid_o=1, kind=REG, rd=1, data=0x00000005.
REQ-024 Dual commit in one cycle: ch0 STORE to addr 0x1000 with data 0xAB, ch1 LOAD x10 from 0x1000 -> records pop in the order STORE then LOAD, and count_o goes 0 to 2.
REQ-025 Filtering: pc=0 with update_i=1 -> no push and drop_cnt_o unchanged; LOAD with rd=0 -> kind NONE.
REQ-026 Overflow: DEPTH=16, rec_ready_i=0, 15 records already stored, then 2 candidates in one cycle -> both dropped, count_o=15, drop_cnt_o=2, ovf_o=1.
REQ-027 Full FIFO with pop and push in the same cycle: push is rejected and count_o=DEPTH-1; a push on the next cycle is accepted.
REQ-028 Reset asserted with 5 records stored -> count_o=0 and rec_valid_o=0 immediately; with TRACE_TSTAMP_EN defined, the first record after reset deasserts carries a small tstamp value.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared commit-trace record types; the tstamp field exists only with TRACE_TSTAMP_EN.
package riscv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {NONE, REG, LOAD, STORE} trace_kind_e;
    typedef struct packed {
        trace_kind_e     kind;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] addr;
`ifdef TRACE_TSTAMP_EN
        logic [31:0]     tstamp;
`endif
    } trace_rec_t;
endpackage

// File: rtl/trace_classify.sv
// trace_classify: turns one channel's commit signals into a trace record (tstamp left 0).
module trace_classify
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    input  logic [4:0]      reg_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            rf_we,
    input  logic            mem_re,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_raddr,
    input  logic [XLEN-1:0] mem_waddr,
    input  logic [XLEN-1:0] mem_wdata,
    output trace_rec_t      rec
);
    always_comb begin
        rec = '0;
        rec.pc = pc;
        rec.instr = instr;
        if (mem_we) begin
            rec.kind = STORE;
            rec.addr = mem_waddr;
            rec.data = mem_wdata;
        end else if (mem_re && reg_addr != '0) begin
            rec.kind = LOAD;
            rec.rd = reg_addr;
            rec.data = reg_data;
            rec.addr = mem_raddr;
        end else if (!mem_re && rf_we && reg_addr != '0) begin
            rec.kind = REG;
            rec.rd = reg_addr;
            rec.data = reg_data;
        end
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: multi-channel commit trace FIFO with all-or-nothing enqueue and drop accounting.
// Define TRACE_TSTAMP_EN to stamp each record with a free-running cycle counter.
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CH    = 2,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [CH-1:0]            update_i,
    input  logic [CH-1:0][XLEN-1:0]  pc_i,
    input  logic [CH-1:0][XLEN-1:0]  instr_i,
    input  logic [CH-1:0][4:0]       reg_addr_i,
    input  logic [CH-1:0][XLEN-1:0]  reg_data_i,
    input  logic [CH-1:0]            rf_we_i,
    input  logic [CH-1:0]            mem_re_i,
    input  logic [CH-1:0]            mem_we_i,
    input  logic [CH-1:0][XLEN-1:0]  mem_raddr_i,
    input  logic [CH-1:0][XLEN-1:0]  mem_waddr_i,
    input  logic [CH-1:0][XLEN-1:0]  mem_wdata_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output trace_rec_t               rec_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              drop_cnt_o,
    output logic                     ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_rec_t        mem [DEPTH];
    trace_rec_t        rec_c [CH];
    trace_rec_t        rec_w [CH];
    logic [CH-1:0]     cand;
    logic [CW-1:0]     n;
    logic [CW-1:0]     off [CH];
    logic [AW-1:0]     wptr, rptr;
    logic              acc, pop;
    logic [32:0]       drop_sum;

`ifdef TRACE_TSTAMP_EN
    logic [31:0] tstamp_q;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) tstamp_q <= '0;
        else tstamp_q <= tstamp_q + 32'd1;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        trace_classify #(.XLEN(XLEN)) u_cls (
            .pc(pc_i[i]), .instr(instr_i[i]), .reg_addr(reg_addr_i[i]), .reg_data(reg_data_i[i]),
            .rf_we(rf_we_i[i]), .mem_re(mem_re_i[i]), .mem_we(mem_we_i[i]),
            .mem_raddr(mem_raddr_i[i]), .mem_waddr(mem_waddr_i[i]), .mem_wdata(mem_wdata_i[i]),
            .rec(rec_c[i])
        );
        assign cand[i] = update_i[i] && pc_i[i] != '0;
    end

    // off[c] is the slot offset of channel c among this cycle's candidates, keeping channel order
    always_comb begin
        n = '0;
        for (int c = 0; c < CH; c++) begin
            off[c] = n;
            n = n + CW'(cand[c]);
            rec_w[c] = rec_c[c];
`ifdef TRACE_TSTAMP_EN
            rec_w[c].tstamp = tstamp_q;
`endif
        end
    end

    // free space is judged before this cycle's pop, so a pop never makes room for a same-cycle push
    assign acc = n <= CW'(DEPTH) - count_o;
    assign rec_valid_o = count_o != '0;
    assign pop = rec_valid_o && rec_ready_i;
    assign rec_o = rec_valid_o ? mem[rptr] : '0;
    assign drop_sum = {1'b0, drop_cnt_o} + 33'(n);

    always_ff @(posedge clk)
        for (int c = 0; c < CH; c++)
            if (acc && cand[c]) mem[wptr + AW'(off[c])] <= rec_w[c];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            count_o <= '0;
            drop_cnt_o <= '0;
            ovf_o <= 1'b0;
        end else begin
            if (acc) wptr <= wptr + AW'(n);
            rptr <= rptr + AW'(pop);
            count_o <= count_o + (acc ? n : '0) - CW'(pop);
            if (!acc) begin
                drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
                ovf_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed self-checking bench for commit_trace_buffer (CH=2, DEPTH=16).
module tb_commit_trace_buffer;
    import riscv_pkg::*;

    logic             clk, rstn, rec_valid, rec_ready, ovf;
    logic [1:0]       update, rf_we, mem_re, mem_we;
    logic [1:0][31:0] pc, instr, reg_data, mem_raddr, mem_waddr, mem_wdata;
    logic [1:0][4:0]  reg_addr;
    trace_rec_t       rec;
    logic [4:0]       count;
    logic [31:0]      drop;
    int               errors = 0, checks = 0;

    commit_trace_buffer #(.CH(2), .DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .update_i(update), .pc_i(pc), .instr_i(instr),
        .reg_addr_i(reg_addr), .reg_data_i(reg_data), .rf_we_i(rf_we), .mem_re_i(mem_re),
        .mem_we_i(mem_we), .mem_raddr_i(mem_raddr), .mem_waddr_i(mem_waddr),
        .mem_wdata_i(mem_wdata), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
        .rec_o(rec), .count_o(count), .drop_cnt_o(drop), .ovf_o(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        update = '0; rf_we = '0; mem_re = '0; mem_we = '0;
        pc = '0; instr = '0; reg_data = '0; reg_addr = '0;
        mem_raddr = '0; mem_waddr = '0; mem_wdata = '0;
    endtask

    task automatic set_reg(input int c, input logic [31:0] p, input logic [4:0] rd, input logic [31:0] d);
        update[c] = 1'b1; pc[c] = p; instr[c] = 32'h00000013;
        reg_addr[c] = rd; reg_data[c] = d; rf_we[c] = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; rec_ready = 1'b0; clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rec_valid), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_drop", 64'(drop), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_rec_zero", 64'(rec === '0), 1);
        rstn = 1'b1;

        // single REG commit
        set_reg(0, 32'h80000004, 5'd1, 32'd5); instr[0] = 32'h00500093;
        tick(); clear();
        chk("reg_valid", 64'(rec_valid), 1);
        chk("reg_count", 64'(count), 1);
        chk("reg_kind", 64'(rec.kind), 64'(REG));
        chk("reg_rd", 64'(rec.rd), 1);
        chk("reg_data", 64'(rec.data), 5);
        chk("reg_pc", 64'(rec.pc), 64'h80000004);
        chk("reg_instr", 64'(rec.instr), 64'h00500093);
        rec_ready = 1'b1; tick(); rec_ready = 1'b0;
        chk("reg_pop_count", 64'(count), 0);
        chk("reg_pop_valid", 64'(rec_valid), 0);

        // dual commit: STORE on ch0, LOAD on ch1
        update = 2'b11; pc[0] = 32'h80000008; pc[1] = 32'h8000000c;
        mem_we[0] = 1'b1; mem_waddr[0] = 32'h1000; mem_wdata[0] = 32'hab;
        mem_re[1] = 1'b1; rf_we[1] = 1'b1; reg_addr[1] = 5'd10; reg_data[1] = 32'hab; mem_raddr[1] = 32'h1000;
        tick(); clear();
        chk("dual_count", 64'(count), 2);
        chk("dual_kind0", 64'(rec.kind), 64'(STORE));
        chk("dual_addr0", 64'(rec.addr), 64'h1000);
        chk("dual_data0", 64'(rec.data), 64'hab);
        chk("dual_rd0", 64'(rec.rd), 0);
        tick();
        chk("stall_kind", 64'(rec.kind), 64'(STORE));
        chk("stall_count", 64'(count), 2);
        rec_ready = 1'b1; tick();
        chk("dual_count1", 64'(count), 1);
        chk("dual_kind1", 64'(rec.kind), 64'(LOAD));
        chk("dual_rd1", 64'(rec.rd), 10);
        chk("dual_addr1", 64'(rec.addr), 64'h1000);
        tick(); rec_ready = 1'b0;
        chk("dual_empty", 64'(count), 0);

        // filtering: pc=0 discarded, LOAD to x0 becomes NONE
        update = 2'b11; pc[0] = 32'h0; rf_we[0] = 1'b1; reg_addr[0] = 5'd2;
        pc[1] = 32'h80000010; mem_re[1] = 1'b1; mem_raddr[1] = 32'h2000; reg_data[1] = 32'h55;
        tick(); clear();
        chk("flt_count", 64'(count), 1);
        chk("flt_drop", 64'(drop), 0);
        chk("flt_kind", 64'(rec.kind), 64'(NONE));
        chk("flt_pc", 64'(rec.pc), 64'h80000010);
        chk("flt_zero_fields", 64'({rec.rd, rec.data, rec.addr} === '0), 1);
        rec_ready = 1'b1; tick(); rec_ready = 1'b0;
        set_reg(0, 32'h80000020, 5'd3, 32'd7); update = '0;
        tick(); clear();
        chk("noupd_count", 64'(count), 0);

        // fill to 15, then an oversize dual push is dropped whole
        for (int k = 0; k < 7; k++) begin
            set_reg(0, 32'h80000100 + 32'(8 * k), 5'd4, 32'(k));
            set_reg(1, 32'h80000104 + 32'(8 * k), 5'd5, 32'(k));
            tick();
        end
        clear(); set_reg(0, 32'h80000138, 5'd6, 32'd1); tick(); clear();
        chk("fill_count", 64'(count), 15);
        set_reg(0, 32'h80000500, 5'd7, 32'd1); set_reg(1, 32'h80000504, 5'd8, 32'd2);
        tick(); clear();
        chk("ovf_count", 64'(count), 15);
        chk("ovf_drop", 64'(drop), 2);
        chk("ovf_flag", 64'(ovf), 1);
        chk("ovf_head", 64'(rec.pc), 64'h80000100);
        set_reg(0, 32'h80000200, 5'd9, 32'd3); tick(); clear();
        chk("full_count", 64'(count), 16);
        chk("full_drop", 64'(drop), 2);

        // full: same-cycle pop does not admit the push
        rec_ready = 1'b1; set_reg(0, 32'h80000300, 5'd9, 32'd4);
        tick(); rec_ready = 1'b0; clear();
        chk("popfull_count", 64'(count), 15);
        chk("popfull_drop", 64'(drop), 3);
        chk("popfull_head", 64'(rec.pc), 64'h80000104);
        set_reg(0, 32'h80000304, 5'd9, 32'd5); tick(); clear();
        chk("nextpush_count", 64'(count), 16);
        chk("nextpush_drop", 64'(drop), 3);
        chk("ovf_sticky", 64'(ovf), 1);

        // asynchronous reset mid-operation
        rstn = 1'b0; #1;
        chk("arst_count", 64'(count), 0);
        chk("arst_valid", 64'(rec_valid), 0);
        chk("arst_drop", 64'(drop), 0);
        chk("arst_ovf", 64'(ovf), 0);
        rstn = 1'b1;
        set_reg(0, 32'h80000600, 5'd1, 32'd1); set_reg(1, 32'h80000604, 5'd2, 32'd2); tick();
        set_reg(0, 32'h80000608, 5'd3, 32'd3); set_reg(1, 32'h8000060c, 5'd4, 32'd4); tick();
        clear(); set_reg(0, 32'h80000610, 5'd5, 32'd5); tick(); clear();
        chk("five_count", 64'(count), 5);
        #2 rstn = 1'b0; #1;
        chk("arst5_count", 64'(count), 0);
        chk("arst5_valid", 64'(rec_valid), 0);
        rstn = 1'b1;
        set_reg(0, 32'h80000400, 5'd1, 32'd9); tick(); clear();
        chk("post_rst_count", 64'(count), 1);
        chk("post_rst_pc", 64'(rec.pc), 64'h80000400);
`ifdef TRACE_TSTAMP_EN
        chk("post_rst_tstamp", 64'(rec.tstamp), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
